// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM stream reader: FSM state encoding and length-width helpers.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rsr_state_e;

  localparam int ADDR_WIDTH_DEF = 9;
  localparam int LEN_WIDTH      = ADDR_WIDTH_DEF + 1;

  // A burst may cover the whole RAM, so the length needs one bit more than an address.
  function automatic int len_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/ram_stream_reader_fifo2_skid.sv
// Two-entry FIFO holding captured RAM words with their last tag; absorbs one cycle
// of read latency so the reader never loses a word under backpressure.
module fifo2_skid #(
  parameter int W = 65
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push_s;
  logic         do_pop_s;

  assign do_pop_s  = pop_i && (count_q != 2'd0);
  assign do_push_s = push_i && ((count_q != 2'd2) || do_pop_s);

  // Storage, pointers and occupancy; entries are zeroed on reset so the head reads 0.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/ram_stream_reader.sv
// Burst reader for a one-cycle-latency block RAM: issues sequential reads with wrap-around
// and presents the words as a valid/ready stream with a last marker.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                cmd_valid_i,
  output logic                                cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]               cmd_addr_i,
  input  logic [len_width(ADDR_WIDTH)-1:0]    cmd_len_i,
  output logic [ADDR_WIDTH-1:0]               rd_addr_o,
  input  logic [WIDTH-1:0]                    rd_data_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [WIDTH-1:0]                    out_data_o,
  output logic                                out_last_o,
  output logic                                busy_o,
  output logic                                done_o
);

  localparam int LW = len_width(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [LW-1:0]         LEN_ZERO  = LW'(0);
  localparam logic [LW-1:0]         LEN_ONE   = LW'(1);

  rsr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [LW-1:0]         remaining_q, remaining_d;
  logic                  inflight_q, inflight_d;
  logic                  infl_last_q, infl_last_d;
  logic                  done_q, done_d;

  logic                  fifo_full_s, fifo_empty_s, pop_s, room_s;
  logic [1:0]            occ_s;
  logic [WIDTH:0]        fifo_head_s;

  function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_LAST) ? '0 : a + ADDR_ONE;
  endfunction

  assign pop_s = !fifo_empty_s && out_ready_i;
  assign occ_s = fifo_full_s ? 2'd2 : (fifo_empty_s ? 2'd0 : 2'd1);
  // Issue only if the word still fits once the pending read and this cycle's pop settle.
  assign room_s = ({1'b0, occ_s} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_s});

  // Next-state and datapath decisions for the burst FSM.
  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    remaining_d = remaining_q;
    inflight_d  = 1'b0;
    infl_last_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          next_addr_d = cmd_addr_i;
          remaining_d = cmd_len_i;
          if (cmd_len_i == LEN_ZERO) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (room_s) begin
          inflight_d  = 1'b1;
          infl_last_d = (remaining_q == LEN_ONE);
          remaining_d = remaining_q - LEN_ONE;
          if (remaining_q == LEN_ONE) begin
            state_d = ST_DRAIN;
          end else begin
            next_addr_d = wrap_inc(next_addr_q);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Leave as the final word is consumed so cmd_ready returns together with done.
        if (!inflight_q && (fifo_empty_s || (pop_s && !fifo_full_s))) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Burst state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      next_addr_q <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

  fifo2_skid #(
    .W(WIDTH + 1)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (inflight_q),
    .data_i  ({infl_last_q, rd_data_i}),
    .pop_i   (pop_s),
    .data_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign rd_addr_o   = next_addr_q;
  assign cmd_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign out_valid_o = !fifo_empty_s;
  assign out_data_o  = fifo_head_s[WIDTH-1:0];
  assign out_last_o  = fifo_head_s[WIDTH];

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Read-side companion to the team's simple dual-port block RAM. Accepts a burst command (start address, length), drives the RAM's read-address port, absorbs the RAM's one-cycle read latency, and presents the words as a valid/ready stream with a last marker. It sits between the message/cost RAMs of the BP engine and the downstream compute pipeline and tolerates arbitrary backpressure without losing or duplicating words.

## Interface
- WIDTH, 64, data word width; must match the attached RAM
- DEPTH, 512, RAM depth in words
- ADDR_WIDTH, 9, RAM address width; DEPTH <= 2**ADDR_WIDTH
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  burst command offered
- cmd_ready  out  1  block can accept a command
- cmd_addr  in  ADDR_WIDTH  first word address
- cmd_len  in  ADDR_WIDTH+1  word count, 0..DEPTH
- rd_addr  out  ADDR_WIDTH  to RAM read address (addr_b)
- rd_data  in  WIDTH  from RAM read data (d_out)
- out_valid  out  1  out_data holds a word
- out_ready  in  1  consumer accepts word
- out_data  out  WIDTH  streamed word
- out_last  out  1  final word of burst, qualified by out_valid
- busy  out  1  burst in progress (state != IDLE)
- done  out  1  one-cycle pulse when a burst completes

## Operation
- FSM states IDLE, RUN, DRAIN. Reset -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready: latch next_addr=cmd_addr, remaining=cmd_len. If cmd_len=0 -> stay IDLE, pulse done next cycle, emit no words. Else -> RUN.
- RUN: each cycle a read may issue: rd_addr=next_addr, inflight<=1, next_addr increments, wrapping DEPTH-1 -> 0 (also for non-power-of-two DEPTH), remaining decrements. Issue allowed when occupancy+inflight-pop < 2 (pop = out_valid&out_ready). When the last read issues -> DRAIN.
- Reads carry a tag bit "last" = (remaining==1) through the inflight register into the FIFO.
- The cycle after an issue, rd_data is captured with its last tag into a 2-entry FIFO. FIFO head drives out_data/out_last; out_valid = FIFO not empty.
- DRAIN: no new reads; when inflight=0 and FIFO empty -> IDLE, done=1 for exactly that transition cycle.
- cmd_ready=0 outside IDLE; commands offered then are held off, never dropped.
- rd_addr holds its last value when not issuing (RAM reads every cycle; unflagged data ignored).
- Read-during-write on the same address returns the RAM's old contents; ordering against writers is the caller's responsibility.
- Synchronous reset mid-burst: FSM -> IDLE, FIFO and inflight cleared, remaining/next_addr cleared; partial burst abandoned, no done pulse.

## Timing
- Reset values: cmd_ready=1 (IDLE), out_valid=0, out_last=0, out_data=0, rd_addr=0, busy=0, done=0.
- Command accepted at edge E0; first read issued cycle 1 (rd_addr=cmd_addr); RAM data cycle 2 captured at E2; first out_valid cycle 3.
- With out_ready held high: one word per cycle, burst of N occupies out_valid cycles 3..N+2; done in cycle N+3; cmd_ready back in cycle N+3 (next command accepted no earlier than that edge).
- out_ready low: at most 2 words buffered; issue stalls; out_data/out_last stable while out_valid&!out_ready.
- Simultaneous pop and capture with FIFO full-minus-one: legal, occupancy unchanged.

## Structure
- Shared package: FSM state enum (IDLE/RUN/DRAIN), LEN_WIDTH = ADDR_WIDTH+1 constant.
- Sub-module fifo2_skid: 2-entry, WIDTH+1 bits (data+last), push/pop/full/empty, synchronous active-low reset. Reader instantiates it once.

## Test plan
- Preload RAM[i]=i; cmd addr=10 len=4, out_ready=1 -> out_data 10,11,12,13 in cycles 3-6, out_last only on 13, done in cycle 7.
- cmd addr=510 len=4 (DEPTH=512) -> rd_addr 510,511,0,1; data 510,511,0,1 in order.
- len=8, out_ready toggling 1,0,0,1,... random -> exactly 8 words in order, no duplicate/loss, out_data stable while stalled, never >2 buffered.
- cmd_len=0 -> no out_valid, done pulse one cycle after acceptance, cmd_ready stays 1.
- Second cmd_valid held during a burst of 3 -> cmd_ready=0 until done cycle; second burst starts after, streams follow back to back correctly.
- rst_n low for one cycle mid-burst of 16 after 5 words -> next cycle out_valid=0, busy=0, cmd_ready=1, no done; fresh burst len=2 streams correctly.
